param_assoc_cache: RTL and testbench
====================================

Name: param_assoc_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache between the CPU model and main_memory.
- Successor to the fixed single-configuration cache: configurable address/data width, block size, set count and associativity.
- Adds explicit req/ready handshakes on both sides, dirty-victim writeback and true LRU replacement.
- Memory traffic is word-serial: one bus beat per word.

Parameters:
- ADDR_W, 10: byte-address width.
- DATA_W, 32: word width; word = 4 bytes, address bits [1:0] ignored.
- BLOCK_WORDS, 4: words per block; power of 2, ≥ 1.
- NUM_SETS, 4: number of sets; power of 2, ≥ 1.
- WAYS, 2: associativity; allowed values 1, 2 or 4.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- CPU_req  in  1  CPU request valid.
- CPU_rOw  in  1  0 = read, 1 = write.
- CPU_address  in  ADDR_W  byte address.
- CPU_writeData  in  DATA_W  store data.
- CPU_ready  out  1  one-cycle completion pulse.
- cache_readData  out  DATA_W  load data; valid when CPU_ready = 1.
- cache_hit  out  1  1 = access hit; valid when CPU_ready = 1.
- cache_req  out  1  memory beat request.
- cache_rOw  out  1  0 = read beat, 1 = write beat.
- cache_address  out  ADDR_W  word-aligned beat address.
- cache_writeData  out  DATA_W  writeback data.
- main_readData  in  DATA_W  refill data.
- main_ready  in  1  beat complete; read data valid in the same cycle.

Behaviour:
- Address split, low to high: byte[1:0] | word offset (log2 BLOCK_WORDS) | set (log2 NUM_SETS) | tag (remainder).
  - Defaults: word [3:2], set [5:4], tag [9:6].
- Reset (asynchronous, active-high): all valid, dirty and LRU state cleared; FSM to IDLE.
  - Outputs on reset: CPU_ready 0, cache_hit 0, cache_readData 0, cache_req 0, cache_rOw 0, cache_address 0, cache_writeData 0.
  - Reset mid-transaction abandons the beat immediately; no partial line is marked valid.
- IDLE:
  - CPU_req = 1 at a clock edge → latch rOw/address/writeData; go to LOOKUP.
  - CPU_req is ignored in all other states. The CPU holds the request until CPU_ready.
- LOOKUP (one cycle):
  - Tag compare across all ways of the set.
  - Hit → CPU_ready = 1 and cache_hit = 1 this cycle.
    - Read: cache_readData = addressed word.
    - Write: word and dirty bit updated at the cycle-end edge.
    - Update LRU; return to IDLE.
  - Hit latency: CPU_ready asserts exactly 1 cycle after the accept edge.
  - Miss → select victim: lowest-index invalid way, else the LRU way.
    - Victim valid and dirty → WRITEBACK; otherwise → REFILL.
- WRITEBACK:
  - BLOCK_WORDS write beats, words 0..BLOCK_WORDS-1, at victim-tag/set addresses.
  - cache_req, cache_rOw = 1, address and data held stable until main_ready.
  - Next beat begins the following cycle. After the last beat → REFILL.
- REFILL:
  - BLOCK_WORDS read beats on the missing block, word 0 first.
  - Each word is captured on the edge where main_ready = 1.
  - After the last beat: tag written, valid = 1, dirty = 0 → RESPOND.
- RESPOND (one cycle):
  - Performs the read or write on the new line.
  - CPU_ready = 1, cache_hit = 0 (miss reported even though the data is now present).
  - Write miss sets dirty. Update LRU. → IDLE.
- LRU:
  - Per-way age counters of log2(WAYS) bits; accessed way gets age 0.
  - Ways younger than the old age increment. Victim = age WAYS-1.
  - WAYS = 1: LRU logic absent.
- cache_req is 0 in IDLE, LOOKUP and RESPOND.
- main_ready is ignored when cache_req = 0.
- CPU_ready is never asserted for two consecutive cycles.

Optional Feature:
- Macro CACHE_PERF_CNT_EN.
- When defined, adds output ports hit_count[15:0] and miss_count[15:0]:
  - Each increments on a CPU_ready pulse with cache_hit = 1 or 0 respectively.
  - Saturate at 0xFFFF; cleared by reset.
- When undefined, the ports and logic are absent and the rest of the behaviour is identical.

Test Plan:
- Reset, then read 0x000 → cache_req read beats at 0x000/0x004/0x008/0x00C; CPU_ready with cache_hit = 0, cache_readData = mem[0x000].
- Read 0x004 → CPU_ready 1 cycle after accept, cache_hit = 1, data = mem[0x004], no cache_req.
- Write 0x008 = 0xDEADBEEF, then read 0x008 → both hits, read returns 0xDEADBEEF, no memory beats.
- Read 0x040, then read 0x080 → 0x040 fills way 1. 0x080 evicts dirty tag 0: write beats 0x000..0x00C (0xDEADBEEF at 0x008), then read beats 0x080..0x08C; cache_hit = 0.
- main_ready delayed 3 cycles per beat → cache_req/address/data held stable until main_ready; correct final data.
- Assert reset during the 2nd refill beat → cache_req drops with no clock edge; a following read of the same address misses. With CACHE_PERF_CNT_EN: counters read 0 after reset, and 2 hits/1 miss after three accesses.

Source files
------------

// File: rtl/param_assoc_cache.sv
// Parametrised N-way set-associative write-back cache with word-serial memory bus.
// Define CACHE_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
module param_assoc_cache #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int NUM_SETS    = 4,
    parameter int WAYS        = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              CPU_req,
    input  logic              CPU_rOw,
    input  logic [ADDR_W-1:0] CPU_address,
    input  logic [DATA_W-1:0] CPU_writeData,
    output logic              CPU_ready,
    output logic [DATA_W-1:0] cache_readData,
    output logic              cache_hit,
    output logic              cache_req,
    output logic              cache_rOw,
    output logic [ADDR_W-1:0] cache_address,
    output logic [DATA_W-1:0] cache_writeData,
    input  logic [DATA_W-1:0] main_readData,
    input  logic              main_ready
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int OB = $clog2(BLOCK_WORDS);
    localparam int SB = $clog2(NUM_SETS);
    localparam int OW = (OB > 0) ? OB : 1;
    localparam int SW = (SB > 0) ? SB : 1;
    localparam int LW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TW = ADDR_W - 2 - OB - SB;
    localparam logic [OW-1:0] LAST = OW'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
    state_t state;

    logic [DATA_W-1:0] data [WAYS][NUM_SETS][BLOCK_WORDS];
    logic [TW-1:0]     tags [WAYS][NUM_SETS];
    logic [WAYS-1:0]   valid [NUM_SETS];
    logic [WAYS-1:0]   dirty [NUM_SETS];
    logic [LW-1:0]     age [NUM_SETS][WAYS];

    logic              rw_q, hit_q;
    logic [DATA_W-1:0] wdata_q;
    logic [TW-1:0]     tag_q;
    logic [SW-1:0]     set_q;
    logic [OW-1:0]     off_q, beat, nbeat;
    logic [LW-1:0]     way_q;

    function automatic logic [OW-1:0] f_off(input logic [ADDR_W-1:0] a);
        return OW'((a >> 2) & ADDR_W'(BLOCK_WORDS - 1));
    endfunction

    function automatic logic [SW-1:0] f_set(input logic [ADDR_W-1:0] a);
        return SW'((a >> (2 + OB)) & ADDR_W'(NUM_SETS - 1));
    endfunction

    function automatic logic [TW-1:0] f_tag(input logic [ADDR_W-1:0] a);
        return TW'(a >> (2 + OB + SB));
    endfunction

    function automatic logic [ADDR_W-1:0] f_addr(input logic [TW-1:0] t,
                                                 input logic [SW-1:0] s,
                                                 input logic [OW-1:0] o);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(t);
        a = (a << SB) | ADDR_W'(s);
        a = (a << OB) | ADDR_W'(o);
        return a << 2;
    endfunction

    logic [TW-1:0]     in_tag;
    logic [SW-1:0]     in_set;
    logic [OW-1:0]     in_off;
    logic              hit_c, free_c, touch;
    logic [LW-1:0]     hway_c, vway_c;
    logic [DATA_W-1:0] rd_c;

    assign in_tag = f_tag(CPU_address);
    assign in_set = f_set(CPU_address);
    assign in_off = f_off(CPU_address);
    assign rd_c   = data[hway_c][in_set][in_off];
    assign nbeat  = beat + 1'b1;
    assign touch  = (state == LOOKUP && hit_q) || state == RESPOND;

    // Lookup runs on the incoming address so hit outputs can be registered at accept.
    always_comb begin
        hit_c  = 1'b0;
        free_c = 1'b0;
        hway_c = '0;
        vway_c = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[in_set][w] && tags[w][in_set] == in_tag) begin
                hit_c  = 1'b1;
                hway_c = LW'(w);
            end
            if (!valid[in_set][w]) begin
                free_c = 1'b1;
                vway_c = LW'(w);
            end
        end
        if (!free_c) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (age[in_set][w] == LW'(WAYS - 1)) vway_c = LW'(w);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (touch && rw_q) data[way_q][set_q][off_q] <= wdata_q;
        if (state == REFILL && main_ready) begin
            data[way_q][set_q][beat] <= main_readData;
            if (beat == LAST) tags[way_q][set_q] <= tag_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            CPU_ready       <= 1'b0;
            cache_hit       <= 1'b0;
            cache_readData  <= '0;
            cache_req       <= 1'b0;
            cache_rOw       <= 1'b0;
            cache_address   <= '0;
            cache_writeData <= '0;
            rw_q            <= 1'b0;
            hit_q           <= 1'b0;
            wdata_q         <= '0;
            tag_q           <= '0;
            set_q           <= '0;
            off_q           <= '0;
            way_q           <= '0;
            beat            <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) age[s][w] <= '0;
            end
`ifdef CACHE_PERF_CNT_EN
            hit_count  <= '0;
            miss_count <= '0;
`endif
        end else begin
            CPU_ready <= 1'b0;
            unique case (state)
                IDLE: if (CPU_req) begin
                    rw_q           <= CPU_rOw;
                    wdata_q        <= CPU_writeData;
                    tag_q          <= in_tag;
                    set_q          <= in_set;
                    off_q          <= in_off;
                    hit_q          <= hit_c;
                    way_q          <= hit_c ? hway_c : vway_c;
                    CPU_ready      <= hit_c;
                    cache_hit      <= hit_c;
                    cache_readData <= rd_c;
                    state          <= LOOKUP;
                end
                LOOKUP: begin
                    beat <= '0;
                    if (hit_q) begin
                        if (rw_q) dirty[set_q][way_q] <= 1'b1;
                        state <= IDLE;
                    end else if (valid[set_q][way_q] && dirty[set_q][way_q]) begin
                        cache_req       <= 1'b1;
                        cache_rOw       <= 1'b1;
                        cache_address   <= f_addr(tags[way_q][set_q], set_q, '0);
                        cache_writeData <= data[way_q][set_q][0];
                        state           <= WRITEBACK;
                    end else begin
                        cache_req     <= 1'b1;
                        cache_rOw     <= 1'b0;
                        cache_address <= f_addr(tag_q, set_q, '0);
                        state         <= REFILL;
                    end
                end
                WRITEBACK: if (main_ready) begin
                    if (beat == LAST) begin
                        beat          <= '0;
                        cache_rOw     <= 1'b0;
                        cache_address <= f_addr(tag_q, set_q, '0);
                        state         <= REFILL;
                    end else begin
                        beat            <= nbeat;
                        cache_address   <= f_addr(tags[way_q][set_q], set_q, nbeat);
                        cache_writeData <= data[way_q][set_q][nbeat];
                    end
                end
                REFILL: if (main_ready) begin
                    if (beat == LAST) begin
                        valid[set_q][way_q] <= 1'b1;
                        dirty[set_q][way_q] <= 1'b0;
                        cache_req           <= 1'b0;
                        CPU_ready           <= 1'b1;
                        cache_hit           <= 1'b0;
                        cache_readData      <= (off_q == beat) ? main_readData
                                                               : data[way_q][set_q][off_q];
                        state               <= RESPOND;
                    end else begin
                        beat          <= nbeat;
                        cache_address <= f_addr(tag_q, set_q, nbeat);
                    end
                end
                RESPOND: begin
                    if (rw_q) dirty[set_q][way_q] <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Ageing ways at or below the old age also resolves the all-zero reset state.
            if (WAYS > 1 && touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (LW'(w) == way_q)
                        age[set_q][w] <= '0;
                    else if (age[set_q][w] <= age[set_q][way_q] &&
                             age[set_q][w] != LW'(WAYS - 1))
                        age[set_q][w] <= age[set_q][w] + 1'b1;
                end
            end
`ifdef CACHE_PERF_CNT_EN
            if (CPU_ready && cache_hit && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (CPU_ready && !cache_hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
`endif
        end
    end

endmodule

// File: tb/tb_param_assoc_cache.sv
// Scoreboard bench for param_assoc_cache: reference cache model plus memory responder.
// Covers directed eviction/writeback, delayed beats, random traffic and mid-refill reset.
module tb_param_assoc_cache;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int NS = 4;
    localparam int NW = 2;
    localparam int MW = 256;

    logic          clock, reset, CPU_req, CPU_rOw;
    logic [AW-1:0] CPU_address;
    logic [DW-1:0] CPU_writeData;
    logic          CPU_ready, cache_hit, cache_req, cache_rOw, main_ready;
    logic [DW-1:0] cache_readData, cache_writeData, main_readData;
    logic [AW-1:0] cache_address;
`ifdef CACHE_PERF_CNT_EN
    logic [15:0]   hit_count, miss_count;
`endif

    param_assoc_cache dut (
        .clock(clock), .reset(reset),
        .CPU_req(CPU_req), .CPU_rOw(CPU_rOw),
        .CPU_address(CPU_address), .CPU_writeData(CPU_writeData),
        .CPU_ready(CPU_ready), .cache_readData(cache_readData),
        .cache_hit(cache_hit), .cache_req(cache_req),
        .cache_rOw(cache_rOw), .cache_address(cache_address),
        .cache_writeData(cache_writeData), .main_readData(main_readData),
        .main_ready(main_ready)
`ifdef CACHE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    typedef struct packed {
        logic          row;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic          hit;
        logic          rw;
        logic [DW-1:0] data;
        int            acc;
    } exp_t;

    beat_t beat_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    beats_done = 0;
    int    fixed_delay = -1;
    int    n_hit = 0;
    int    n_miss = 0;
    int    tick = 0;
    bit    in_beat = 0;

    logic [DW-1:0] ref_mem [MW];
    logic [DW-1:0] bus_mem [MW];
    bit            mv [NS][NW];
    bit            md [NS][NW];
    int            mt [NS][NW];
    int            ms [NS][NW];
    logic [DW-1:0] mdat [NS][NW][BW];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, want);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                mv[s][w] = 0;
                md[s][w] = 0;
                ms[s][w] = 0;
            end
        n_hit  = 0;
        n_miss = 0;
    endtask

    // Reference: plain lookup, LRU by last-use timestamp, whole-line moves.
    task automatic model_access(input bit rw, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd, output exp_t e);
        int wa, off, set, tg, way, base;
        beat_t b;
        wa  = int'(a >> 2);
        off = wa % BW;
        set = (wa / BW) % NS;
        tg  = wa / (BW * NS);
        way = -1;
        for (int w = 0; w < NW; w++)
            if (mv[set][w] && mt[set][w] == tg) way = w;
        e.hit = (way >= 0);
        e.rw  = rw;
        if (way < 0) begin
            for (int w = NW - 1; w >= 0; w--)
                if (!mv[set][w]) way = w;
            if (way < 0) begin
                way = 0;
                for (int w = 1; w < NW; w++)
                    if (ms[set][w] < ms[set][way]) way = w;
            end
            if (mv[set][way] && md[set][way]) begin
                base = (mt[set][way] * NS + set) * BW;
                for (int k = 0; k < BW; k++) begin
                    b.row  = 1;
                    b.addr = AW'((base + k) * 4);
                    b.data = mdat[set][way][k];
                    beat_q.push_back(b);
                    ref_mem[base + k] = mdat[set][way][k];
                end
            end
            base = (tg * NS + set) * BW;
            for (int k = 0; k < BW; k++) begin
                b.row  = 0;
                b.addr = AW'((base + k) * 4);
                b.data = '0;
                beat_q.push_back(b);
                mdat[set][way][k] = ref_mem[base + k];
            end
            mv[set][way] = 1;
            md[set][way] = 0;
            mt[set][way] = tg;
        end
        e.data = mdat[set][way][off];
        if (rw) begin
            mdat[set][way][off] = wd;
            md[set][way] = 1;
        end
        tick++;
        ms[set][way] = tick;
        if (e.hit) n_hit++;
        else n_miss++;
    endtask

    task automatic issue(input bit rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, output exp_t e);
        @(posedge clock);
        #1;
        model_access(rw, a, wd, e);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        CPU_rOw       = rw;
        CPU_address   = a;
        CPU_writeData = wd;
        CPU_req       = 1;
    endtask

    task automatic access(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        exp_t e;
        bit seen;
        int b0;
        b0 = beats_done;
        seen = 0;
        issue(rw, a, wd, e);
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clock);
            seen = CPU_ready;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout addr %0h got no ready want ready", a);
        end
        @(posedge clock);
        #1;
        CPU_req = 0;
        if (e.hit) chk("hit_no_beats", 64'(beats_done), 64'(b0));
    endtask

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    // Monitor: pops the scoreboard whenever the DUT completes an access.
    initial begin
        bit   prev;
        exp_t e;
        prev = 0;
        forever begin
            @(negedge clock);
            if (reset) prev = 0;
            else begin
                if (CPU_ready) begin
                    chk("ready_back_to_back", 64'(prev), 64'(0));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ready_unexpected got ready want none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("hit", 64'(cache_hit), 64'(e.hit));
                        if (!e.rw) chk("read_data", 64'(cache_readData), 64'(e.data));
                        if (e.hit) chk("hit_latency", 64'(cyc), 64'(e.acc));
                    end
                end
                prev = CPU_ready;
            end
        end
    end

    // Memory responder: checks each beat against expectations, holds for a delay.
    initial begin
        int            cnt, d;
        logic [AW-1:0] b_addr;
        logic          b_row;
        logic [DW-1:0] b_wd;
        beat_t         e;
        main_ready    = 0;
        main_readData = '0;
        cnt = 0;
        d = 0;
        b_addr = '0;
        b_row = 0;
        b_wd = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                in_beat    = 0;
                main_ready = 0;
            end else begin
                if (main_ready) begin
                    main_ready = 0;
                    in_beat    = 0;
                    beats_done++;
                end
                if (cache_req) begin
                    if (!in_beat) begin
                        in_beat = 1;
                        cnt     = 0;
                        d       = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
                        b_addr  = cache_address;
                        b_row   = cache_rOw;
                        b_wd    = cache_writeData;
                        if (beat_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL beat_unexpected got addr %0h want none", b_addr);
                        end else begin
                            e = beat_q.pop_front();
                            chk("beat_rOw", 64'(b_row), 64'(e.row));
                            chk("beat_addr", 64'(b_addr), 64'(e.addr));
                            if (e.row) chk("beat_wdata", 64'(b_wd), 64'(e.data));
                        end
                    end else begin
                        chk("beat_hold_addr", 64'(cache_address), 64'(b_addr));
                        chk("beat_hold_rOw", 64'(cache_rOw), 64'(b_row));
                        if (b_row) chk("beat_hold_wdata", 64'(cache_writeData), 64'(b_wd));
                        cnt++;
                    end
                    if (cnt == d) begin
                        main_ready = 1;
                        if (b_row) bus_mem[int'(b_addr >> 2)] = b_wd;
                        else main_readData = bus_mem[int'(b_addr >> 2)];
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        bit   hit_b;
        int   bd;
        int   tg, st, of, lo;
        CPU_req       = 0;
        CPU_rOw       = 0;
        CPU_address   = '0;
        CPU_writeData = '0;
        reset         = 1;
        for (int i = 0; i < MW; i++) begin
            ref_mem[i] = $urandom;
            bus_mem[i] = ref_mem[i];
        end
        model_reset();
        #3;
        chk("rst_CPU_ready", 64'(CPU_ready), 64'(0));
        chk("rst_cache_hit", 64'(cache_hit), 64'(0));
        chk("rst_readData", 64'(cache_readData), 64'(0));
        chk("rst_cache_req", 64'(cache_req), 64'(0));
        chk("rst_cache_rOw", 64'(cache_rOw), 64'(0));
        chk("rst_cache_address", 64'(cache_address), 64'(0));
        chk("rst_cache_writeData", 64'(cache_writeData), 64'(0));
`ifdef CACHE_PERF_CNT_EN
        chk("rst_hit_count", 64'(hit_count), 64'(0));
        chk("rst_miss_count", 64'(miss_count), 64'(0));
`endif
        repeat (2) @(negedge clock);
        #2;
        reset = 0;

        access(0, 10'h000, '0);
        access(0, 10'h004, '0);
        access(1, 10'h008, 32'hDEADBEEF);
`ifdef CACHE_PERF_CNT_EN
        chk("perf_hits_3", 64'(hit_count), 64'(2));
        chk("perf_miss_3", 64'(miss_count), 64'(1));
`endif
        access(0, 10'h008, '0);
        access(0, 10'h040, '0);
        access(0, 10'h080, '0);

        fixed_delay = 3;
        access(1, 10'h0C4, 32'h1234_5678);
        access(0, 10'h008, '0);
        access(0, 10'h04C, '0);
        access(0, 10'h0C4, '0);
        access(1, 10'h104, 32'hCAFE_F00D);
        access(0, 10'h144, '0);
        fixed_delay = -1;

        for (int i = 0; i < 250; i++) begin
            tg = $urandom_range(0, 5);
            st = $urandom_range(0, 3);
            of = $urandom_range(0, 3);
            lo = $urandom_range(0, 3);
            hit_b = ($urandom_range(0, 1) == 1);
            access(hit_b, AW'(tg * 64 + st * 16 + of * 4 + lo), $urandom);
        end
`ifdef CACHE_PERF_CNT_EN
        chk("perf_hits_rand", 64'(hit_count), 64'(n_hit));
        chk("perf_miss_rand", 64'(miss_count), 64'(n_miss));
`endif

        @(posedge clock);
        #1;
        reset = 1;
        model_reset();
        #3;
        reset = 0;
        fixed_delay = 3;
        bd = beats_done;
        issue(0, 10'h100, '0, e);
        hit_b = 0;
        for (int i = 0; i < 200 && !hit_b; i++) begin
            @(negedge clock);
            #1;
            hit_b = (beats_done == bd + 1) && in_beat;
        end
        chk("reach_second_beat", 64'(hit_b), 64'(1));
        #2;
        reset = 1;
        #1;
        chk("abort_cache_req", 64'(cache_req), 64'(0));
        chk("abort_CPU_ready", 64'(CPU_ready), 64'(0));
        chk("abort_cache_address", 64'(cache_address), 64'(0));
        CPU_req = 0;
        exp_q.delete();
        beat_q.delete();
        model_reset();
        @(negedge clock);
        #2;
        reset = 0;
`ifdef CACHE_PERF_CNT_EN
        chk("abort_hit_count", 64'(hit_count), 64'(0));
        chk("abort_miss_count", 64'(miss_count), 64'(0));
`endif
        fixed_delay = -1;
        access(0, 10'h100, '0);
        access(0, 10'h104, '0);
`ifdef CACHE_PERF_CNT_EN
        chk("post_hit_count", 64'(hit_count), 64'(1));
        chk("post_miss_count", 64'(miss_count), 64'(1));
`endif

        repeat (4) @(negedge clock);
        chk("exp_drained", 64'(exp_q.size()), 64'(0));
        chk("beats_drained", 64'(beat_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
